// File: rtl/wb_decoder_pkg.sv
// Shared bus definitions for the wishbone address decoder: widths, slot map,
// request record and decoder state encoding.
package wb_decoder_pkg;

    localparam int DAT_WIDTH = 64;
    localparam int ADR_WIDTH = 64;
    localparam int SEL_WIDTH = DAT_WIDTH / 8;
    localparam int NUM_SLOTS = 3;
    localparam int SLOT_W    = 2;

    localparam int SLOT_RAM = 0;
    localparam int SLOT_ROM = 1;
    localparam int SLOT_IO  = 2;

    typedef logic [SLOT_W-1:0]    slot_t;
    typedef logic [ADR_WIDTH-1:0] adr_t;
    typedef logic [DAT_WIDTH-1:0] dat_t;
    typedef logic [SEL_WIDTH-1:0] sel_t;

    localparam adr_t RAM_BASE = 64'h0000_0000_0000_0000;
    localparam adr_t RAM_SIZE = 64'h0000_0000_0001_0000;
    localparam adr_t ROM_BASE = 64'h0000_8000_0000_0000;
    localparam adr_t ROM_SIZE = 64'h0000_0000_0001_0000;
    localparam adr_t IO_BASE  = 64'h0000_F000_0000_0000;
    localparam adr_t IO_SIZE  = 64'h0000_0000_0000_1000;

    // Indexed by slot number: [0]=RAM, [1]=ROM, [2]=IO
    localparam logic [NUM_SLOTS-1:0][ADR_WIDTH-1:0] SLOT_BASE = {IO_BASE, ROM_BASE, RAM_BASE};
    localparam logic [NUM_SLOTS-1:0][ADR_WIDTH-1:0] SLOT_SIZE = {IO_SIZE, ROM_SIZE, RAM_SIZE};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic we;
        sel_t sel;
        adr_t adr;
        dat_t dat;
    } wb_req_t;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational slot lookup: address -> slot index, hit flag, offset in slot.
module wb_addr_decode
    import wb_decoder_pkg::*;
(
    input  logic [ADR_WIDTH-1:0] adr,
    output logic [SLOT_W-1:0]    slot,
    output logic                 hit,
    output logic [ADR_WIDTH-1:0] offset
);

    always_comb begin
        slot   = '0;
        hit    = 1'b0;
        offset = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            // Unsigned wrap makes addresses below the base fail the size test
            if (!hit && ((adr - SLOT_BASE[k]) < SLOT_SIZE[k])) begin
                hit    = 1'b1;
                slot   = slot_t'(k);
                offset = adr - SLOT_BASE[k];
            end
        end
    end

endmodule

// File: rtl/wb_decoder.sv
// Single-master, three-slave wishbone decoder with bus-error on unmapped
// addresses and on slave timeout.
module wb_decoder
    import wb_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           m_cyc_i,
    input  logic                           m_stb_i,
    input  logic                           m_we_i,
    input  logic [SEL_WIDTH-1:0]           m_sel_i,
    input  logic [ADR_WIDTH-1:0]           m_adr_i,
    input  logic [DAT_WIDTH-1:0]           m_dat_i,
    output logic [DAT_WIDTH-1:0]           m_dat_o,
    output logic                           m_ack_o,
    output logic                           m_err_o,
    output logic [NUM_SLOTS-1:0]           s_cyc_o,
    output logic [NUM_SLOTS-1:0]           s_stb_o,
    output logic                           s_we_o,
    output logic [SEL_WIDTH-1:0]           s_sel_o,
    output logic [ADR_WIDTH-1:0]           s_adr_o,
    output logic [DAT_WIDTH-1:0]           s_dat_o,
    input  logic [NUM_SLOTS*DAT_WIDTH-1:0] s_dat_i,
    input  logic [NUM_SLOTS-1:0]           s_ack_i,
    input  logic [NUM_SLOTS-1:0]           s_err_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    wb_state_e            state, state_nxt;
    wb_req_t              req_q;
    slot_t                slot_q;
    logic                 unmapped_q;
    logic [7:0]           cnt_q;

    slot_t                dec_slot;
    logic                 dec_hit;
    adr_t                 dec_off;

    logic [NUM_SLOTS-1:0] slot_oh;
    logic                 sel_ack, sel_err;
    dat_t                 sel_dat;
    logic                 req_take, timeout;

    wb_addr_decode u_dec (
        .adr    (m_adr_i),
        .slot   (dec_slot),
        .hit    (dec_hit),
        .offset (dec_off)
    );

    // Only the registered slot's responses are ever looked at
    always_comb begin
        slot_oh = '0;
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_q == slot_t'(k)) begin
                slot_oh[k] = 1'b1;
                sel_ack    = s_ack_i[k];
                sel_err    = s_err_i[k];
                sel_dat    = s_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end

    assign req_take = m_cyc_i && m_stb_i;
    assign timeout  = (cnt_q == TO_LAST);

    always_comb begin
        state_nxt = state;
        m_ack_o   = 1'b0;
        m_err_o   = 1'b0;
        m_dat_o   = '0;
        case (state)
            ST_IDLE: begin
                if (req_take) state_nxt = dec_hit ? ST_ACTIVE : ST_DONE;
            end
            ST_ACTIVE: begin
                if (!m_cyc_i) begin
                    // Master abandoned the cycle: no response is reported
                    state_nxt = ST_IDLE;
                end else begin
                    m_dat_o = req_q.we ? '0 : sel_dat;
                    // Priority: slave error, then ack, then timeout
                    if (sel_err)      m_err_o = 1'b1;
                    else if (sel_ack) m_ack_o = 1'b1;
                    else if (timeout) m_err_o = 1'b1;
                    if (sel_err || sel_ack || timeout) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                m_err_o   = unmapped_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            slot_q     <= '0;
            unmapped_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_take) begin
                req_q      <= '{we: m_we_i, sel: m_sel_i, adr: dec_off, dat: m_dat_i};
                slot_q     <= dec_slot;
                unmapped_q <= !dec_hit;
                cnt_q      <= '0;
            end else if (state == ST_ACTIVE) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign s_cyc_o = (state == ST_ACTIVE) ? slot_oh : '0;
    assign s_stb_o = (state == ST_ACTIVE) ? slot_oh : '0;
    assign s_we_o  = req_q.we;
    assign s_sel_o = req_q.sel;
    assign s_adr_o = req_q.adr;
    assign s_dat_o = req_q.dat;

endmodule

// File: tb/tb_wb_decoder.sv
// Directed bench for wb_decoder: ROM read, RAM write, unmapped, timeout,
// ack/err collision, master abort and asynchronous reset.
module tb_wb_decoder;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         m_cyc_i, m_stb_i, m_we_i;
    logic [7:0]   m_sel_i;
    logic [63:0]  m_adr_i, m_dat_i, m_dat_o;
    logic         m_ack_o, m_err_o;
    logic [2:0]   s_cyc_o, s_stb_o;
    logic         s_we_o;
    logic [7:0]   s_sel_o;
    logic [63:0]  s_adr_o, s_dat_o;
    logic [191:0] s_dat_i;
    logic [2:0]   s_ack_i, s_err_i;

    int n_chk  = 0;
    int n_fail = 0;

    wb_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_sel_i (m_sel_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_sel_o (s_sel_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic [7:0] sel, input logic [63:0] adr,
                       input logic [63:0] dat);
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = we;
        m_sel_i = sel;
        m_adr_i = adr;
        m_dat_i = dat;
    endtask

    task automatic release_bus;
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = '0;
        s_err_i = '0;
    endtask

    initial begin
        rst_i   = 1'b0;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_sel_i = '0;   m_adr_i = '0;   m_dat_i = '0;
        s_dat_i = '0;   s_ack_i = '0;   s_err_i = '0;
        #2;
        chk("rst_cyc",  s_cyc_o, 3'b000);
        chk("rst_stb",  s_stb_o, 3'b000);
        chk("rst_we",   s_we_o,  1'b0);
        chk("rst_sel",  s_sel_o, 8'h00);
        chk("rst_adr",  s_adr_o, 64'h0);
        chk("rst_sdat", s_dat_o, 64'h0);
        chk("rst_ack",  m_ack_o, 1'b0);
        chk("rst_err",  m_err_o, 1'b0);
        chk("rst_mdat", m_dat_o, 64'h0);
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        tick;

        // ROM read, ack on second ACTIVE cycle; stray RAM err must be ignored
        req(1'b0, 8'hFF, 64'h0000_8000_0000_0008, 64'h0);
        s_dat_i[63:0]   = 64'h1111;
        s_dat_i[127:64] = 64'hDEAD_BEEF;
        s_err_i = 3'b001;
        tick;
        chk("rom_cyc",   s_cyc_o, 3'b010);
        chk("rom_adr",   s_adr_o, 64'h8);
        chk("rom_ack1",  m_ack_o, 1'b0);
        chk("rom_noerr", m_err_o, 1'b0);
        s_err_i = '0;
        tick;
        s_ack_i = 3'b010;
        #1;
        chk("rom_ack",  m_ack_o, 1'b1);
        chk("rom_dat",  m_dat_o, 64'hDEAD_BEEF);
        tick;
        release_bus;
        #1;
        chk("rom_done_ack", m_ack_o, 1'b0);
        chk("rom_done_cyc", s_cyc_o, 3'b000);
        chk("rom_done_dat", m_dat_o, 64'h0);
        tick;
        chk("rom_idle_stb", s_stb_o, 3'b000);

        // RAM write
        req(1'b1, 8'h0F, 64'h10, 64'h55);
        tick;
        chk("wr_cyc", s_cyc_o, 3'b001);
        chk("wr_we",  s_we_o,  1'b1);
        chk("wr_sel", s_sel_o, 8'h0F);
        chk("wr_dat", s_dat_o, 64'h55);
        chk("wr_adr", s_adr_o, 64'h10);
        s_ack_i = 3'b001;
        s_dat_i[63:0] = 64'hABCD;
        #1;
        chk("wr_ack",  m_ack_o, 1'b1);
        chk("wr_rdat", m_dat_o, 64'h0);
        tick;
        release_bus;
        #1;
        chk("wr_done_ack", m_ack_o, 1'b0);
        tick;

        // Unmapped address
        req(1'b0, 8'hFF, 64'h0000_4000_0000_0000, 64'h0);
        #1;
        chk("um_idle_err", m_err_o, 1'b0);
        tick;
        chk("um_stb", s_stb_o, 3'b000);
        chk("um_err", m_err_o, 1'b1);
        chk("um_ack", m_ack_o, 1'b0);
        release_bus;
        tick;
        chk("um_err_clr", m_err_o, 1'b0);

        // IO slot never answers: error on 16th ACTIVE cycle
        req(1'b0, 8'hFF, 64'h0000_F000_0000_0010, 64'h0);
        tick;
        for (int i = 1; i <= 16; i++) begin
            chk((i == 16) ? "to_err16" : "to_err", m_err_o, (i == 16) ? 64'h1 : 64'h0);
            if (i < 16) tick;
        end
        chk("to_stb16", s_stb_o, 3'b100);
        tick;
        chk("to_stb_drop", s_stb_o, 3'b000);
        chk("to_err_done", m_err_o, 1'b0);
        release_bus;
        tick;

        // Ack arriving on the timeout cycle wins
        req(1'b0, 8'hFF, 64'h0000_F000_0000_0020, 64'h0);
        tick;
        repeat (15) tick;
        s_ack_i = 3'b100;
        #1;
        chk("toa_ack", m_ack_o, 1'b1);
        chk("toa_err", m_err_o, 1'b0);
        tick;
        release_bus;
        #1;
        chk("toa_done_ack", m_ack_o, 1'b0);
        tick;

        // Simultaneous ack and err; master keeps stb up afterwards
        req(1'b0, 8'hFF, 64'h20, 64'h0);
        tick;
        s_ack_i = 3'b001;
        s_err_i = 3'b001;
        #1;
        chk("both_err", m_err_o, 1'b1);
        chk("both_ack", m_ack_o, 1'b0);
        tick;
        s_ack_i = '0;
        s_err_i = '0;
        #1;
        chk("hold_done_stb", s_stb_o, 3'b000);
        chk("hold_done_err", m_err_o, 1'b0);
        tick;
        chk("hold_idle_stb", s_stb_o, 3'b000);
        tick;
        chk("hold_new_stb", s_stb_o, 3'b001);
        s_ack_i = 3'b001;
        #1;
        chk("hold_new_ack", m_ack_o, 1'b1);
        tick;
        release_bus;
        tick;

        // Master drops cyc mid-transaction
        req(1'b0, 8'hFF, 64'h30, 64'h0);
        tick;
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_ack_i = 3'b001;
        #1;
        chk("drop_ack", m_ack_o, 1'b0);
        chk("drop_err", m_err_o, 1'b0);
        tick;
        chk("drop_cyc", s_cyc_o, 3'b000);
        s_ack_i = '0;
        #1;
        chk("drop_idle_ack", m_ack_o, 1'b0);
        tick;

        // Asynchronous reset during ACTIVE, then first request after release
        req(1'b0, 8'hFF, 64'h40, 64'h77);
        s_dat_i[63:0] = 64'h1234;
        tick;
        chk("pre_rst_dat", m_dat_o, 64'h1234);
        chk("pre_rst_cyc", s_cyc_o, 3'b001);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_cyc",  s_cyc_o, 3'b000);
        chk("arst_stb",  s_stb_o, 3'b000);
        chk("arst_sel",  s_sel_o, 8'h00);
        chk("arst_adr",  s_adr_o, 64'h0);
        chk("arst_sdat", s_dat_o, 64'h0);
        chk("arst_mdat", m_dat_o, 64'h0);
        chk("arst_ack",  m_ack_o, 1'b0);
        m_adr_i = 64'h0000_8000_0000_0000;
        #2 rst_i = 1'b1;
        tick;
        chk("first_req_cyc", s_cyc_o, 3'b010);
        s_ack_i = 3'b010;
        #1;
        chk("first_req_ack", m_ack_o, 1'b1);
        tick;
        release_bus;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_decoder.md
WB_DECODER -- requirements
Module: wb_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning cycles in ACTIVE without slave ack/err before bus error (legal range 2..255).
REQ-002 SHALL have ports: clk_i in 1 clock; rst_i in 1 asynchronous active-low reset.
REQ-003 SHALL have master-side ports (CPU bus): m_cyc_i in 1; m_stb_i in 1; m_we_i in 1; m_sel_i in 8 byte lanes; m_adr_i in 64; m_dat_i in 64 write data; m_dat_o out 64 read data; m_ack_o out 1; m_err_o out 1.
REQ-004 SHALL have slave-side ports: s_cyc_o out 3 one-hot; s_stb_o out 3 one-hot; s_we_o out 1; s_sel_o out 8; s_adr_o out 64 offset within slot; s_dat_o out 64; s_dat_i in 192 (slave k at bits 64k+63:64k); s_ack_i in 3; s_err_i in 3.

Function
REQ-005 SHALL decode m_adr_i: slot 0 RAM 0x0000_0000_0000..0x0000_0000_FFFF; slot 1 ROM 0x8000_0000_0000..0x8000_0000_FFFF; slot 2 IO 0xF000_0000_0000..0xF000_0000_0FFF; all else unmapped.
REQ-006 SHALL implement states IDLE, ACTIVE, DONE.
REQ-007 IDLE: when m_cyc_i & m_stb_i, SHALL register slot, we, sel, dat and offset (m_adr_i minus slot base) and go to ACTIVE; unmapped address goes to DONE with m_err_o high for that next cycle.
REQ-008 ACTIVE: s_cyc_o/s_stb_o SHALL be asserted for the registered slot only, first cycle one clock after request sampling; s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL hold registered values.
REQ-009 ACTIVE: m_ack_o SHALL equal selected s_ack_i combinationally; m_dat_o SHALL equal selected slave data; on ack or err SHALL go to DONE at that edge.
REQ-010 Slave ack and err in same cycle: err SHALL win (m_err_o=1, m_ack_o=0).
REQ-011 Timeout counter SHALL clear on entering ACTIVE, increment each ACTIVE cycle without ack/err; at TIMEOUT_CYCLES-1 SHALL assert m_err_o one cycle, drop slave cyc/stb, go DONE; ack in that same cycle SHALL win over timeout.
REQ-012 m_cyc_i deasserted during ACTIVE SHALL drop slave cyc/stb next edge, return to IDLE, no ack/err issued.
REQ-013 DONE SHALL last exactly one cycle, ignore m_stb_i, drive all slave strobes low, then go IDLE; a still-asserted request is re-sampled in IDLE as new.
REQ-014 m_ack_o and m_err_o SHALL never both be high, and each SHALL be high at most one cycle per request.
REQ-015 m_dat_o SHALL be 0 outside ACTIVE and for writes.
REQ-016 Unused slave inputs (non-selected slots) SHALL be ignored.

Reset
REQ-017 rst_i low SHALL immediately force state IDLE, counter 0, s_cyc_o=s_stb_o=0, s_we_o=0, s_sel_o=0, s_adr_o=0, s_dat_o=0, m_ack_o=m_err_o=0, m_dat_o=0, including mid-transaction.
REQ-018 First request SHALL be sampled on the first rising edge after rst_i deasserts.

Structure
REQ-019 Slot bases, sizes, slot indices, DAT_WIDTH/ADR_WIDTH and state encodings SHALL live in the shared bus package alongside the wishbone definitions.
REQ-020 Address decode SHALL be one sub-module, wb_addr_decode (combinational: address in -> slot index, hit flag, offset).

Verification
REQ-021 Read 0x8000_0000_0008, ROM acks 2nd ACTIVE cycle with 0xDEAD_BEEF -> s_adr_o=0x8, m_ack_o one cycle, m_dat_o=0xDEAD_BEEF, DONE then IDLE.
REQ-022 Write 0x10 data 0x55 sel 0x0F, RAM acks -> s_cyc_o=3'b001, s_we_o=1, s_sel_o=0x0F, s_dat_o=0x55, single m_ack_o.
REQ-023 Access 0x4000_0000_0000 -> no slave strobe, m_err_o high exactly one cycle after request.
REQ-024 IO slot never responds -> m_err_o on 16th ACTIVE cycle, s_stb_o low next cycle; ack on that same cycle instead -> ack only.
REQ-025 Simultaneous s_ack_i/s_err_i on RAM -> m_err_o=1, m_ack_o=0; master holds stb after ack -> DONE one cycle then new transaction.
REQ-026 rst_i low during ACTIVE -> all outputs 0 without waiting for clock; m_cyc_i drop in ACTIVE -> IDLE, no ack.
